// File: rtl/ic_1533ir8_rx.sv
// ---------------------------------------------------------------------------
// ic_1533ir8_rx -- serial-to-parallel byte receiver with output holding
// register, consume handshake and sticky overrun flag.
//
// A frame starts on an edge with SE=1 and FS=1. That edge carries data bit 7,
// and the remaining bits follow MSB first on later SE=1 edges. When the last
// data bit (or the parity bit) is sampled, the byte is offered to the
// consumer through Q/VLD.
//
// Optional feature macro: IR8_PARITY_EN
//   defined   : 8 data bits plus a 9th even-parity bit sampled in state PAR;
//               PERR is loaded together with Q (1 = parity error).
//   undefined : 8-bit frames, no PAR state, PERR tied to 0.
//
// Ports
//   C    in   clock, rising edge active
//   R    in   asynchronous active-low reset
//   DI   in   serial data, sampled only when SE=1
//   SE   in   shift enable (0 = hold)
//   FS   in   frame start, qualified by SE=1
//   ACK  in   consumer accepts Q
//   CLR  in   clears OVR
//   SR   out  [7:0] live shift register contents
//   Q    out  [7:0] last delivered byte
//   VLD  out  Q holds an unconsumed byte
//   OVR  out  sticky overrun flag
//   PERR out  parity error for the byte in Q
// ---------------------------------------------------------------------------
module ic_1533ir8_rx (
  input  logic       C,
  input  logic       R,
  input  logic       DI,
  input  logic       SE,
  input  logic       FS,
  input  logic       ACK,
  input  logic       CLR,
  output logic [7:0] SR,
  output logic [7:0] Q,
  output logic       VLD,
  output logic       OVR,
  output logic       PERR
);

`ifdef IR8_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  q_q, q_d;
  logic        vld_q, vld_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  shifted_s;
  logic [7:0]  new_byte_s;
  logic        done_s;
  logic        ovr_set_s;
`ifdef IR8_PARITY_EN
  logic        perr_q, perr_d;
  logic        new_perr_s;
`endif

  assign shifted_s = {sr_q[6:0], DI};

  // Frame sequencing: shift register, bit counter and state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    done_s     = 1'b0;
    new_byte_s = shifted_s;
`ifdef IR8_PARITY_EN
    new_perr_s = 1'b0;
`endif
    if (SE) begin
      if (FS) begin
        // A frame start in any state begins a fresh frame; this edge is bit 7.
        sr_d    = shifted_s;
        cnt_d   = 4'd1;
        state_d = SHIFT;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          SHIFT: begin
            sr_d  = shifted_s;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
`ifdef IR8_PARITY_EN
              state_d = PAR;
`else
              state_d    = IDLE;
              cnt_d      = 4'd0;
              done_s     = 1'b1;
              new_byte_s = shifted_s;
`endif
            end else begin
              state_d = SHIFT;
            end
          end
`ifdef IR8_PARITY_EN
          PAR: begin
            // Parity bit is not shifted in; SR keeps the data byte.
            state_d    = IDLE;
            cnt_d      = 4'd0;
            done_s     = 1'b1;
            new_byte_s = sr_q;
            new_perr_s = (^sr_q) ^ DI;
          end
`endif
          default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output holding register: delivery, consume and overrun.
  always_comb begin
    q_d       = q_q;
    vld_d     = vld_q;
    ovr_set_s = 1'b0;
`ifdef IR8_PARITY_EN
    perr_d    = perr_q;
`endif
    if (done_s) begin
      // A same-edge ACK frees the slot, so the new byte replaces the old one.
      if (!vld_q || ACK) begin
        q_d   = new_byte_s;
        vld_d = 1'b1;
`ifdef IR8_PARITY_EN
        perr_d = new_perr_s;
`endif
      end else begin
        ovr_set_s = 1'b1;
      end
    end else if (vld_q && ACK) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
    // Setting the overrun flag takes priority over clearing it.
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (CLR) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and data registers.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= 8'd0;
      q_q     <= 8'd0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef IR8_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
`ifdef IR8_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign SR  = sr_q;
  assign Q   = q_q;
  assign VLD = vld_q;
  assign OVR = ovr_q;
`ifdef IR8_PARITY_EN
  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_ic_1533ir8_rx.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ic_1533ir8_rx. Expected bytes (and parity flags)
// are pushed to a scoreboard when a frame is driven and popped when the DUT
// presents the byte on Q/VLD. Works with and without IR8_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_ic_1533ir8_rx;

  logic       C, R, DI, SE, FS, ACK, CLR;
  logic [7:0] SR, Q;
  logic       VLD, OVR, PERR;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q_q[$];
  logic       exp_p_q[$];
  logic [7:0] sr_m;

  ic_1533ir8_rx dut (
    .C(C), .R(R), .DI(DI), .SE(SE), .FS(FS), .ACK(ACK), .CLR(CLR),
    .SR(SR), .Q(Q), .VLD(VLD), .OVR(OVR), .PERR(PERR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic edge_wait();
    @(posedge C);
    #1;
  endtask

  // One shifting edge (FS=1 starts a frame); updates the bench SR model.
  task automatic shift_bit(input logic di, input logic fs, input logic ack, input logic clr);
    SE = 1'b1; FS = fs; DI = di; ACK = ack; CLR = clr;
    sr_m = {sr_m[6:0], di};
    edge_wait();
  endtask

  // Parity edge: SR is not shifted.
  task automatic par_bit(input logic p, input logic ack, input logic clr);
    SE = 1'b1; FS = 1'b0; DI = p; ACK = ack; CLR = clr;
    edge_wait();
  endtask

  task automatic idle(input logic ack, input logic clr);
    SE = 1'b0; FS = 1'b0; DI = 1'b0; ACK = ack; CLR = clr;
    edge_wait();
  endtask

  function automatic logic exp_perr(input logic [7:0] b, input logic p);
`ifdef IR8_PARITY_EN
    return (^b) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  // Full frame; ACK/CLR are applied only on the completion edge.
  task automatic send_frame(input logic [7:0] b, input logic ack_last,
                            input logic clr_last, input logic pbit);
    for (int i = 7; i >= 0; i--) begin
`ifdef IR8_PARITY_EN
      shift_bit(b[i], (i == 7), 1'b0, 1'b0);
`else
      shift_bit(b[i], (i == 7), (i == 0) ? ack_last : 1'b0, (i == 0) ? clr_last : 1'b0);
`endif
    end
`ifdef IR8_PARITY_EN
    par_bit(pbit, ack_last, clr_last);
`endif
  endtask

  task automatic test_reset();
    logic [7:0] eq;
    logic ep;
    R = 1'b0; SE = 1'b0; FS = 1'b0; DI = 1'b0; ACK = 1'b0; CLR = 1'b0;
    sr_m = 8'd0;
    edge_wait();
    edge_wait();
    checks++; if (SR !== 8'd0) begin errors++; $display("FAIL reset_sr got %h exp 00", SR); end
    checks++; if (Q !== 8'd0) begin errors++; $display("FAIL reset_q got %h exp 00", Q); end
    checks++; if ({VLD, OVR, PERR} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {VLD, OVR, PERR}); end
    R = 1'b1;
    edge_wait();
    // SE=1 with FS=0 in IDLE must not shift.
    shift_bit(1'b1, 1'b0, 1'b0, 1'b0);
    sr_m = 8'd0;
    checks++; if (SR !== 8'd0) begin errors++; $display("FAIL idle_noshift got %h exp 00", SR); end
    eq = 8'd0; ep = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] eq;
    logic ep;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    exp_q_q.push_back(8'hA5); exp_p_q.push_back(exp_perr(8'hA5, 1'b1));
    checks++; if (VLD !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", VLD); end
    eq = exp_q_q.pop_front(); ep = exp_p_q.pop_front();
    checks++; if (Q !== eq) begin errors++; $display("FAIL basic_q got %h exp %h", Q, eq); end
    checks++; if (PERR !== ep) begin errors++; $display("FAIL basic_perr got %b exp %b", PERR, ep); end
    checks++; if (SR !== sr_m) begin errors++; $display("FAIL basic_sr got %h exp %h", SR, sr_m); end
    idle(1'b1, 1'b0);
    checks++; if (VLD !== 1'b0) begin errors++; $display("FAIL basic_ack got %b exp 0", VLD); end
  endtask

  task automatic test_hold();
    logic [7:0] b;
    logic [7:0] eq;
    b = 8'hA5;
    for (int i = 7; i >= 4; i--) shift_bit(b[i], (i == 7), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      SE = 1'b0; FS = 1'b1; DI = k[0]; ACK = 1'b0; CLR = 1'b0;
      edge_wait();
    end
    checks++; if (SR !== sr_m) begin errors++; $display("FAIL hold_sr got %h exp %h", SR, sr_m); end
    for (int i = 3; i >= 0; i--) shift_bit(b[i], 1'b0, 1'b0, 1'b0);
`ifdef IR8_PARITY_EN
    par_bit(^b, 1'b0, 1'b0);
`endif
    exp_q_q.push_back(b); exp_p_q.push_back(1'b0);
    eq = exp_q_q.pop_front(); void'(exp_p_q.pop_front());
    checks++; if (Q !== eq || VLD !== 1'b1) begin errors++; $display("FAIL hold_q got %h/%b exp %h/1", Q, VLD, eq); end
    checks++; if (SR !== sr_m) begin errors++; $display("FAIL hold_sr_end got %h exp %h", SR, sr_m); end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    logic [7:0] eq;
    send_frame(8'h3C, 1'b0, 1'b0, ^8'h3C);
    exp_q_q.push_back(8'h3C); exp_p_q.push_back(1'b0);
    eq = exp_q_q.pop_front(); void'(exp_p_q.pop_front());
    checks++; if (Q !== eq || VLD !== 1'b1) begin errors++; $display("FAIL ovr_first got %h/%b exp %h/1", Q, VLD, eq); end
    send_frame(8'hC3, 1'b0, 1'b0, ^8'hC3);
    checks++; if (Q !== eq) begin errors++; $display("FAIL ovr_keep got %h exp %h", Q, eq); end
    checks++; if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", OVR); end
    send_frame(8'h5A, 1'b0, 1'b1, ^8'h5A);
    checks++; if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", OVR); end
    idle(1'b0, 1'b1);
    checks++; if (OVR !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", OVR); end
    checks++; if (Q !== eq || VLD !== 1'b1) begin errors++; $display("FAIL ovr_q_after got %h/%b exp %h/1", Q, VLD, eq); end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_ack_same_edge();
    logic [7:0] eq;
    send_frame(8'h3C, 1'b0, 1'b0, ^8'h3C);
    exp_q_q.push_back(8'h3C); exp_p_q.push_back(1'b0);
    eq = exp_q_q.pop_front(); void'(exp_p_q.pop_front());
    checks++; if (Q !== eq) begin errors++; $display("FAIL acksame_first got %h exp %h", Q, eq); end
    send_frame(8'h81, 1'b1, 1'b0, ^8'h81);
    exp_q_q.push_back(8'h81); exp_p_q.push_back(1'b0);
    eq = exp_q_q.pop_front(); void'(exp_p_q.pop_front());
    checks++; if (Q !== eq || VLD !== 1'b1 || OVR !== 1'b0) begin
      errors++; $display("FAIL acksame got q=%h vld=%b ovr=%b exp %h/1/0", Q, VLD, OVR, eq);
    end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_restart();
    logic [7:0] eq;
    for (int i = 0; i < 5; i++) shift_bit(1'b1, (i == 0), 1'b0, 1'b0);
    checks++; if (VLD !== 1'b0) begin errors++; $display("FAIL restart_partial got %b exp 0", VLD); end
    send_frame(8'h0F, 1'b0, 1'b0, ^8'h0F);
    exp_q_q.push_back(8'h0F); exp_p_q.push_back(1'b0);
    eq = exp_q_q.pop_front(); void'(exp_p_q.pop_front());
    checks++; if (Q !== eq || VLD !== 1'b1) begin errors++; $display("FAIL restart_q got %h/%b exp %h/1", Q, VLD, eq); end
    checks++; if (SR !== sr_m) begin errors++; $display("FAIL restart_sr got %h exp %h", SR, sr_m); end
  endtask

  task automatic test_reset_midframe();
    // Q=0F and VLD=1 still pending from the previous test.
    for (int i = 0; i < 4; i++) shift_bit(i[0], (i == 0), 1'b0, 1'b0);
    R = 1'b0;
    #1;
    checks++; if ({SR, Q, VLD, OVR, PERR} !== 19'd0) begin
      errors++; $display("FAIL midreset got sr=%h q=%h flags=%b exp 0", SR, Q, {VLD, OVR, PERR});
    end
    sr_m = 8'd0;
    edge_wait();
    R = 1'b1;
    for (int i = 0; i < 8; i++) begin
      SE = 1'b1; FS = 1'b0; DI = 1'b1; ACK = 1'b0; CLR = 1'b0;
      edge_wait();
    end
    checks++; if (VLD !== 1'b0 || SR !== sr_m) begin errors++; $display("FAIL midreset_nofs got vld=%b sr=%h exp 0/%h", VLD, SR, sr_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [7:0] eq;
    logic ep, pb;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      send_frame(b, (n != 0), 1'b0, pb);
      exp_q_q.push_back(b); exp_p_q.push_back(exp_perr(b, pb));
      eq = exp_q_q.pop_front(); ep = exp_p_q.pop_front();
      checks++; if (Q !== eq || VLD !== 1'b1 || PERR !== ep || OVR !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d got q=%h vld=%b perr=%b ovr=%b exp %h/1/%b/0", n, Q, VLD, PERR, OVR, eq, ep);
      end
    end
    idle(1'b1, 1'b0);
    checks++; if (VLD !== 1'b0) begin errors++; $display("FAIL b2b_final_ack got %b exp 0", VLD); end
    // ACK with VLD=0 must have no effect.
    idle(1'b1, 1'b0);
    checks++; if (VLD !== 1'b0 || Q !== eq) begin errors++; $display("FAIL ack_novld got %b/%h exp 0/%h", VLD, Q, eq); end
  endtask

`ifdef IR8_PARITY_EN
  task automatic test_parity();
    logic [7:0] eq;
    logic ep;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    exp_q_q.push_back(8'hA5); exp_p_q.push_back(1'b1);
    eq = exp_q_q.pop_front(); ep = exp_p_q.pop_front();
    checks++; if (Q !== eq || PERR !== ep) begin errors++; $display("FAIL par_bad got %h/%b exp %h/%b", Q, PERR, eq, ep); end
    idle(1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    exp_q_q.push_back(8'hA5); exp_p_q.push_back(1'b0);
    eq = exp_q_q.pop_front(); ep = exp_p_q.pop_front();
    checks++; if (Q !== eq || PERR !== ep) begin errors++; $display("FAIL par_good got %h/%b exp %h/%b", Q, PERR, eq, ep); end
    idle(1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overrun();
    test_ack_same_edge();
    test_restart();
    test_reset_midframe();
    test_back_to_back();
`ifdef IR8_PARITY_EN
    test_parity();
`endif
    checks++; if (exp_q_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic_1533ir8_rx.md
IC_1533IR8_RX -- requirements
Module: ic_1533ir8_rx

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL provide port C, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL provide port R, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL provide port DI, input, 1 bit: serial data, sampled only when SE=1.
REQ-005 SHALL provide port SE, input, 1 bit: shift enable; SE=0 on an edge means hold.
REQ-006 SHALL provide port FS, input, 1 bit: frame start; qualified by SE=1.
REQ-007 SHALL provide port ACK, input, 1 bit: consumer accepts Q.
REQ-008 SHALL provide port CLR, input, 1 bit: clears OVR.
REQ-009 SHALL provide port SR, output, 8 bits: live shift register contents.
REQ-010 SHALL provide port Q, output, 8 bits: last delivered byte.
REQ-011 SHALL provide port VLD, output, 1 bit: Q holds an unconsumed byte.
REQ-012 SHALL provide port OVR, output, 1 bit: sticky overrun flag.
REQ-013 SHALL provide port PERR, output, 1 bit: parity error for the byte in Q.

Function
REQ-014 SHALL implement states IDLE, SHIFT and PAR; PAR exists only per REQ-030.
REQ-015 SHALL leave IDLE only on an edge with SE=1 and FS=1; SE=1 with FS=0 in IDLE is ignored, and SR is unchanged.
REQ-016 SHALL, on every edge with SE=1 that shifts, update SR as SR <= {SR[6:0], DI}, MSB first; bit counter +1.
REQ-017 SHALL treat the FS edge as data bit 7 (first bit): SR <= {SR[6:0], DI}, and set the counter to 1.
REQ-018 SHALL, on an edge with SE=1 and FS=1 in SHIFT or PAR, discard the partial frame and restart per REQ-017.
REQ-019 SHALL hold SR, the counter and the state on any edge with SE=0; FS with SE=0 is ignored.
REQ-020 SHALL complete a frame on the edge sampling the 8th data bit, or the parity bit if enabled, and then return to IDLE.
REQ-021 SHALL, on completion with VLD=0, load Q <= {SR[6:0], DI}, or the data byte if parity is enabled, and set VLD=1 on the same edge, so it is visible in the next cycle.
REQ-022 SHALL clear VLD on an edge with VLD=1 and ACK=1 and no completion.
REQ-023 SHALL, on completion with VLD=1 and ACK=1 on the same edge, load the new byte, keep VLD=1, and leave OVR unchanged.
REQ-024 SHALL, on completion with VLD=1 and ACK=0, keep Q and PERR, drop the new byte, and set OVR=1.
REQ-025 SHALL clear OVR on an edge with CLR=1; if the same edge also sets OVR, set wins.
REQ-026 SHALL ignore ACK when VLD=0.

Reset
REQ-027 SHALL, while R=0, force SR=0, Q=0, VLD=0, OVR=0, PERR=0, counter=0 and state=IDLE, independent of C.
REQ-028 SHALL discard a partial frame when reset is asserted mid-frame; after release, reception restarts only on FS.
REQ-029 SHALL resume clocked operation on the first rising edge of C after R returns to 1.

Configuration
REQ-030 SHALL honour macro IR8_PARITY_EN: when defined, the frame is 8 data bits plus a 9th even-parity bit sampled in state PAR.
REQ-031 SHALL, with IR8_PARITY_EN defined, load PERR together with Q as the XOR of the 8 data bits and the parity bit; 1 means error, and the byte is still delivered.
REQ-032 SHALL, with IR8_PARITY_EN undefined, omit state PAR, use 8-bit frames, and tie PERR to constant 0.

Verification
REQ-033 SHALL pass this check: apply FS+SE with bits 1,0,1,0,0,1,0,1 on consecutive edges -> Q=8'hA5 and VLD=1 after the 8th edge, and SR=8'hA5.
REQ-034 SHALL pass this check: with SE=0 for 3 edges mid-frame, then the remaining bits -> Q=8'hA5 and no extra shifts.
REQ-035 SHALL pass this check: complete 8'h3C with no ACK, then complete 8'hC3 -> Q stays 8'h3C and OVR=1; CLR=1 -> OVR=0.
REQ-036 SHALL pass this check: ACK on the same edge as completion of 8'h81 -> Q=8'h81, VLD stays 1, OVR=0.
REQ-037 SHALL pass this check: FS restart after 5 bits, then 8 bits of 8'h0F -> Q=8'h0F; R=0 after 4 bits -> all outputs 0 and no byte delivered.
REQ-038 SHALL pass this check, with IR8_PARITY_EN: 8'hA5 with parity bit 1 -> PERR=1; with parity bit 0 -> PERR=0.
